// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, default
// sizing, and burst counter width.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_DONE     = 2'd2
  } arb_state_e;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_MAX_BURST = 16;

  // Bits needed to hold a burst count from 0 up to max_burst.
  function automatic int burst_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  localparam int BURST_W = burst_w(DEF_MAX_BURST);

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: scans requests upward from ptr, wrapping at the top,
// and returns the first requester found as a one-hot vector.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  logic [PW-1:0] idx;

  // First requesting index at or after ptr (modulo N_REQ) wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % N_REQ);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates N_REQ byte requesters onto one UART transmitter. Round-robin
// selection with an optional per-requester burst lock capped at MAX_BURST
// consecutive bytes. All outputs are registered.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_byte,
  input  logic [N_REQ-1:0]   lock,
  output logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   grant,
  output logic               tx_req,
  output logic [7:0]         tx_byte,
  input  logic               tx_ack,
  output logic               busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = burst_w(MAX_BURST);
  // burst_cnt counts re-grants after the opening grant of a burst, so the
  // last permitted re-grant leaves the burst at MAX_BURST bytes in total.
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

  arb_state_e       state, state_d;
  logic [PW-1:0]    ptr, ptr_d;
  logic [CW-1:0]    burst_cnt, burst_d;
  logic [PW-1:0]    owner, owner_d;
  logic             has_owner, has_owner_d;
  logic [N_REQ-1:0] grant_d, req_ack_d;
  logic             tx_req_d, busy_d;
  logic [7:0]       tx_byte_d;

  logic [N_REQ-1:0] rr_win;
  logic             rr_valid;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    sel_idx;
  logic [7:0]       sel_byte;
  logic             lock_hit;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (rr_win),
    .valid  (rr_valid)
  );

  // Previous owner keeps the UART while it requests with lock and has burst budget left.
  assign lock_hit = has_owner && req[owner] && lock[owner] && (burst_cnt < BURST_LAST);

  // Encode the round-robin winner and mux out the selected requester's byte.
  always_comb begin
    win_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rr_win[i]) win_idx = PW'(i);
    end
    sel_idx  = lock_hit ? owner : win_idx;
    sel_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (PW'(i) == sel_idx) sel_byte = req_byte[8*i +: 8];
    end
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_d     = state;
    grant_d     = grant;
    tx_req_d    = tx_req;
    tx_byte_d   = tx_byte;
    req_ack_d   = '0;
    ptr_d       = ptr;
    burst_d     = burst_cnt;
    owner_d     = owner;
    has_owner_d = has_owner;

    case (state)
      ST_IDLE: begin
        grant_d  = '0;
        tx_req_d = 1'b0;
        if (lock_hit) begin
          grant_d[owner] = 1'b1;
          tx_byte_d      = sel_byte;
          tx_req_d       = 1'b1;
          burst_d        = burst_cnt + CW'(1);
          state_d        = ST_WAIT_ACK;
        end else if (rr_valid) begin
          grant_d     = rr_win;
          tx_byte_d   = sel_byte;
          tx_req_d    = 1'b1;
          ptr_d       = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
          burst_d     = '0;
          owner_d     = win_idx;
          has_owner_d = 1'b1;
          state_d     = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (tx_ack) begin
          tx_req_d  = 1'b0;
          req_ack_d = grant;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        // A held or repeated tx_ack keeps us here without re-acking.
        if (!tx_ack) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d  = '0;
        tx_req_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state     <= ST_IDLE;
      grant     <= '0;
      tx_req    <= 1'b0;
      tx_byte   <= '0;
      req_ack   <= '0;
      busy      <= 1'b0;
      ptr       <= '0;
      burst_cnt <= '0;
      owner     <= '0;
      has_owner <= 1'b0;
    end else begin
      state     <= state_d;
      grant     <= grant_d;
      tx_req    <= tx_req_d;
      tx_byte   <= tx_byte_d;
      req_ack   <= req_ack_d;
      busy      <= busy_d;
      ptr       <= ptr_d;
      burst_cnt <= burst_d;
      owner     <= owner_d;
      has_owner <= has_owner_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a transaction-level model.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int MAXB = 16;

  logic           Clk = 1'b0;
  logic           nReset;
  logic [N-1:0]   req, lock, req_ack, grant;
  logic [8*N-1:0] req_byte;
  logic           tx_req, tx_ack, busy;
  logic [7:0]     tx_byte;

  int total = 0;
  int bad   = 0;

  // Reference model state: next search start, last owner, bytes in current burst.
  int m_ptr, m_owner, m_run;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    int         exp;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t tbl [13];

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MAXB)) dut (
    .Clk      (Clk),
    .nReset   (nReset),
    .req      (req),
    .req_byte (req_byte),
    .lock     (lock),
    .req_ack  (req_ack),
    .grant    (grant),
    .tx_req   (tx_req),
    .tx_byte  (tx_byte),
    .tx_ack   (tx_ack),
    .busy     (busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Grant rule: locked owner keeps the UART for up to MAXB bytes in a row,
  // otherwise the first requester at or after the pointer wins.
  function automatic int model_pick(input logic [3:0] r, input logic [3:0] l);
    int w;
    w = -1;
    if (m_owner >= 0 && r[m_owner] == 1'b1 && l[m_owner] == 1'b1 && m_run < MAXB) begin
      w = m_owner;
      m_run++;
    end else begin
      for (int k = 0; k < N; k++)
        if (w < 0 && r[(m_ptr + k) % N] == 1'b1) w = (m_ptr + k) % N;
      m_ptr   = (w + 1) % N;
      m_owner = w;
      m_run   = 1;
    end
    return w;
  endfunction

  task automatic do_reset();
    nReset   = 1'b0;
    req      = '0;
    lock     = '0;
    tx_ack   = 1'b0;
    req_byte = '0;
    m_ptr    = 0;
    m_owner  = -1;
    m_run    = 0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_tx_req", tx_req, 0);
    chk("rst_grant", grant, 0);
    chk("rst_req_ack", req_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_byte", tx_byte, 0);
    nReset = 1'b1;
  endtask

  // One UART transaction: wait for tx_req, hold for dly cycles, ack once.
  task automatic serve(input int exp, input logic [7:0] exp_byte, input int dly, input bit scramble);
    int n;
    logic [N-1:0] oh;
    oh = N'(1) << exp;
    n  = 0;
    while (tx_req !== 1'b1 && n < 20) begin
      @(posedge Clk);
      #1;
      n++;
    end
    if (tx_req !== 1'b1) begin
      chk("tx_req_arrive", {31'b0, tx_req}, 1);
      return;
    end
    chk("grant", grant, oh);
    chk("tx_byte", tx_byte, exp_byte);
    chk("busy_wait", busy, 1);
    for (int k = 0; k < dly; k++) begin
      if (scramble) begin
        req_byte = $urandom;
        req      = N'($urandom);
      end
      @(posedge Clk);
      #1;
      chk("tx_req_hold", tx_req, 1);
      chk("grant_hold", grant, oh);
      chk("tx_byte_hold", tx_byte, exp_byte);
    end
    tx_ack = 1'b1;
    @(posedge Clk);
    #1;
    tx_ack = 1'b0;
    chk("req_ack", req_ack, oh);
    chk("tx_req_after_ack", tx_req, 0);
  endtask

  initial begin
    tbl[0]  = '{4'b1111, 4'b0000, 0, 8'h41};
    tbl[1]  = '{4'b1111, 4'b0000, 1, 8'h42};
    tbl[2]  = '{4'b1111, 4'b0000, 2, 8'h43};
    tbl[3]  = '{4'b1111, 4'b0000, 3, 8'h44};
    tbl[4]  = '{4'b1111, 4'b0000, 0, 8'h41};
    tbl[5]  = '{4'b1001, 4'b0000, 3, 8'h44};
    tbl[6]  = '{4'b1001, 4'b0000, 0, 8'h41};
    tbl[7]  = '{4'b1001, 4'b0000, 3, 8'h44};
    tbl[8]  = '{4'b1001, 4'b0000, 0, 8'h41};
    tbl[9]  = '{4'b0011, 4'b0010, 1, 8'h42};
    tbl[10] = '{4'b0011, 4'b0010, 1, 8'h42};
    tbl[11] = '{4'b0011, 4'b0010, 1, 8'h42};
    tbl[12] = '{4'b0011, 4'b0000, 0, 8'h41};

    do_reset();

    // Single request from requester 2, acked after a few cycles.
    req_byte = 32'h0041_0000;
    req      = 4'b0100;
    @(posedge Clk);
    #1;
    chk("first_tx_req", tx_req, 1);
    chk("first_grant", grant, 4'b0100);
    chk("first_byte", tx_byte, 8'h41);
    serve(2, 8'h41, 4, 1'b0);
    req = '0;
    @(posedge Clk);
    #1;
    chk("req_ack_one_cycle", req_ack, 0);
    chk("tx_req_low", tx_req, 0);
    chk("idle_busy", busy, 0);

    // Reset while waiting for the UART ack; pointer must restart at 0.
    req_byte = 32'h0000_5500;
    req      = 4'b0010;
    @(posedge Clk);
    #1;
    chk("pre_rst_grant", grant, 4'b0010);
    @(posedge Clk);
    #2;
    nReset = 1'b0;
    #1;
    chk("midrst_tx_req", tx_req, 0);
    chk("midrst_grant", grant, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ack", req_ack, 0);
    @(posedge Clk);
    #1;
    nReset   = 1'b1;
    req      = 4'b1111;
    req_byte = 32'h4443_4241;
    serve(0, 8'h41, 1, 1'b0);
    req = '0;

    // Directed vector table: rotation, two-requester alternation, short lock.
    do_reset();
    req_byte = 32'h4443_4241;
    for (int i = 0; i < 13; i++) begin
      req  = tbl[i].req;
      lock = tbl[i].lock;
      serve(tbl[i].exp, tbl[i].exp_byte, i % 3, 1'b0);
    end

    // Lock held for 20 bytes with requester 0 pending: burst caps at MAXB.
    req  = 4'b0011;
    lock = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      int e;
      e = (k < MAXB) ? 1 : ((k == MAXB) ? 0 : 1);
      serve(e, 8'h41 + 8'(e), 0, 1'b0);
    end
    req  = '0;
    lock = '0;

    // Spurious ack while idle.
    repeat (2) @(posedge Clk);
    #1;
    tx_ack = 1'b1;
    @(posedge Clk);
    #1;
    tx_ack = 1'b0;
    chk("spur_idle_tx_req", tx_req, 0);
    chk("spur_idle_req_ack", req_ack, 0);
    chk("spur_idle_busy", busy, 0);
    chk("spur_idle_grant", grant, 0);

    // Ack held across several cycles: single req_ack, stays busy until released.
    req = 4'b0100;
    @(posedge Clk);
    #1;
    chk("held_grant", grant, 4'b0100);
    chk("held_byte", tx_byte, 8'h43);
    tx_ack = 1'b1;
    @(posedge Clk);
    #1;
    req = '0;
    chk("held_req_ack", req_ack, 4'b0100);
    @(posedge Clk);
    #1;
    chk("held_req_ack_off", req_ack, 0);
    chk("held_busy1", busy, 1);
    @(posedge Clk);
    #1;
    chk("held_busy2", busy, 1);
    chk("held_req_ack_off2", req_ack, 0);
    tx_ack = 1'b0;
    @(posedge Clk);
    #1;
    chk("held_release_busy", busy, 0);
    chk("held_release_grant", grant, 0);

    // Randomized traffic checked against the reference model.
    do_reset();
    for (int t = 0; t < 60; t++) begin
      logic [3:0] r, l;
      logic [7:0] eb;
      int w;
      r        = 4'($urandom_range(1, 15));
      l        = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
      req_byte = $urandom;
      req      = r;
      lock     = l;
      w        = model_pick(r, l);
      eb       = req_byte[8*w +: 8];
      serve(w, eb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the UART transmitter.
REQ-002 Parameter MAX_BURST, default 16, max consecutive locked grants to one requester.
REQ-003 Clk  input  1  system clock (25 MHz); single clock domain.
REQ-004 nReset  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  N_REQ  per-requester level request; byte valid while high.
REQ-006 req_byte  input  8*N_REQ  per-requester data byte, requester i at bits [8i+7:8i].
REQ-007 lock  input  N_REQ  per-requester burst hold; keeps grant for the next byte.
REQ-008 req_ack  output  N_REQ  one-cycle pulse: requester's byte taken by UART.
REQ-009 grant  output  N_REQ  one-hot owner of the UART; zero when idle.
REQ-010 tx_req  output  1  byte-ready request to UART transmitter.
REQ-011 tx_byte  output  8  byte to UART transmitter.
REQ-012 tx_ack  input  1  UART acknowledge, one-cycle pulse.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, WAIT_ACK, DONE; all outputs registered.
REQ-015 IDLE: if any req bit high in cycle t, SHALL select a winner, and at t+1 drive grant one-hot, tx_byte = winner's req_byte, tx_req=1, state WAIT_ACK.
REQ-016 IDLE with req all zero: state holds; tx_req=0, grant=0.
REQ-017 Winner selection: round-robin; search starts at index ptr, ascending, wrapping N_REQ-1 -> 0.
REQ-018 ptr SHALL update to (winner+1) mod N_REQ on every non-locked grant.
REQ-019 Locked re-grant: if previous owner has req=1 and lock=1 in IDLE and burst_cnt < MAX_BURST, owner SHALL be re-granted regardless of ptr.
REQ-020 burst_cnt SHALL increment per locked re-grant and clear on any non-locked grant; at MAX_BURST, lock ignored and round-robin applies (ptr = owner+1).
REQ-021 tx_byte and grant SHALL stay stable from WAIT_ACK entry until return to IDLE; req_byte changes meanwhile are ignored.
REQ-022 WAIT_ACK: tx_req held high indefinitely until tx_ack=1; no timeout.
REQ-023 WAIT_ACK with tx_ack=1 in cycle t: at t+1 tx_req=0, req_ack[owner]=1 for exactly one cycle, state DONE.
REQ-024 DONE: if tx_ack=0, go IDLE next cycle; else remain in DONE.
REQ-025 Requesters respond to req_ack by updating req/req_byte in the following cycle; IDLE samples those values (ack-to-next-arbitration = 2 cycles).
REQ-026 Dropping req while owner in WAIT_ACK SHALL NOT cancel; the byte is still sent and acked.
REQ-027 Simultaneous tx_ack and reset: reset wins.
REQ-028 req_ack and grant never address a requester whose req was low at arbitration.
REQ-029 Spurious tx_ack in IDLE or DONE SHALL be ignored.

Reset
REQ-030 nReset low SHALL asynchronously force state IDLE, tx_req=0, tx_byte=0, grant=0, req_ack=0, busy=0, ptr=0, burst_cnt=0.
REQ-031 Reset during WAIT_ACK: byte possibly already in flight at the UART, no req_ack issued; requester re-requests after reset.
REQ-032 Synchronous release; first arbitration on the first edge with nReset high.

Structure
REQ-033 Package uart_arb_pkg SHALL hold FSM state encoding, default N_REQ and MAX_BURST, and burst counter width.
REQ-034 One combinational sub-module rr_pick (req, ptr -> one-hot winner, valid) SHALL implement REQ-017.

Verification
REQ-035 After reset, req[2]=1, byte 0x41; UART model acks 5 cycles after tx_req -> tx_req=1, tx_byte=0x41, grant=0100 one cycle later; req_ack[2] one pulse; tx_req low after ack.
REQ-036 All four req high from reset, lock=0 -> grant order 0,1,2,3, then 0.
REQ-037 req[0], req[3] held high continuously -> grants alternate 0,3,0,3.
REQ-038 req[1] lock=1 for 3 bytes, req[0] pending -> grants 1,1,1,0; lock held 20 bytes with req[0] pending -> 16 grants to 1, then 0.
REQ-039 nReset low mid-WAIT_ACK -> tx_req, grant, busy zero same cycle; no req_ack; next request after release arbitrates from ptr=0.
REQ-040 Integrated with real UART at 115200, requesters 0 and 1 send 'A' (0x41) and 'B' (0x42) -> serial line carries 0x41 then 0x42, each framed with start and stop bit, no lost byte.
